// File: rtl/adc_spi_capture_pkg.sv
// Shared definitions for the ADC SPI capture front-end: FSM state encoding,
// default sample width and the frame-timing legality check that the filter
// top level reuses.
package adc_spi_capture_pkg;

  localparam int DATA_SIZE_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  // A frame must fit conversion, the full serial read and the DONE/IDLE
  // turnaround before the next tick==0.
  function automatic bit cfg_legal(input int data_size, input int fs_div,
                                   input int conv_wait, input int sclk_div);
    return (conv_wait + 2 * sclk_div * data_size + 3) <= fs_div;
  endfunction

endpackage

// File: rtl/adc_spi_capture_spi_shift_rx.sv
// SPI receive engine: SCLK divider, bit counter, registered SDO and the
// MSB-first shift register. A start pulse runs DATA_SIZE SCLK periods
// (low phase then high phase, SCLK_DIV clk cycles each).
import adc_spi_capture_pkg::*;

module adc_spi_capture_spi_shift_rx #(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int SCLK_DIV  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sdo,
  output logic                 sclk,
  output logic                 busy,
  output logic                 last,
  output logic [DATA_SIZE-1:0] shreg
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 sdo_q;
  logic [DATA_SIZE-2:0] shreg_q;
  logic                 phase_end;

  assign phase_end = (div_cnt == DW'(SCLK_DIV - 1));
  // High in the clk cycle that shifts in the final bit.
  assign last      = sclk && phase_end && (bit_cnt == BW'(DATA_SIZE - 1));
  // Word as it stands after the shift of the current cycle; it is the
  // complete sample in the cycle where last is high.
  assign shreg     = {shreg_q, sdo_q};

  // Single retiming register on the ADC data line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sdo_q <= 1'b0;
    else        sdo_q <= sdo;
  end

  // SCLK phase generation and MSB-first shifting at the end of each high phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg_q <= '0;
    end else if (start && !busy) begin
      busy    <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (busy) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (sclk) begin
          shreg_q <= shreg[DATA_SIZE-2:0];
          sclk    <= 1'b0;
          if (bit_cnt == BW'(DATA_SIZE - 1)) busy <= 1'b0;
          else                               bit_cnt <= bit_cnt + BW'(1);
        end else begin
          sclk <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// SPI master front-end for a serial ADC. Runs one conversion + read per
// FS_DIV-cycle frame, presents each sample on data_out with a one-cycle
// sample_trig, and tracks the filter's acknowledge to flag overruns.
// Build option: define ADC_OFFSET_BINARY_EN when the ADC emits offset binary
// (MSB is inverted on load); undefined means the ADC is two's complement.
import adc_spi_capture_pkg::*;

module adc_spi_capture #(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int FS_DIV    = 208,
  parameter int CONV_WAIT = 20,
  parameter int SCLK_DIV  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 adc_sdo,
  output logic                 adc_cnv,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 sample_trig,
  input  logic                 filter_done,
  input  logic                 ovr_clr,
  output logic                 overrun,
  output state_t               state_dbg
);

  localparam int TW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam int CW = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;

  if (!cfg_legal(DATA_SIZE, FS_DIV, CONV_WAIT, SCLK_DIV)) begin : g_cfg_illegal
    $error("adc_spi_capture: CONV_WAIT + 2*SCLK_DIV*DATA_SIZE + 3 exceeds FS_DIV");
  end

  state_t               state;
  logic [TW-1:0]        tick;
  logic [CW-1:0]        conv_cnt;
  logic                 pending;
  logic                 rx_start;
  logic                 rx_busy;
  logic                 rx_last;
  logic [DATA_SIZE-1:0] rx_shreg;
  logic [DATA_SIZE-1:0] sample_word;

  assign state_dbg = state;
  assign rx_start  = (state == CONV) && (conv_cnt == CW'(CONV_WAIT - 1));

`ifdef ADC_OFFSET_BINARY_EN
  assign sample_word = rx_shreg ^ {1'b1, {(DATA_SIZE-1){1'b0}}};
`else
  assign sample_word = rx_shreg;
`endif

  adc_spi_capture_spi_shift_rx #(
    .DATA_SIZE (DATA_SIZE),
    .SCLK_DIV  (SCLK_DIV)
  ) u_rx (
    .clk   (clk),
    .reset (reset),
    .start (rx_start),
    .sdo   (adc_sdo),
    .sclk  (adc_sclk),
    .busy  (rx_busy),
    .last  (rx_last),
    .shreg (rx_shreg)
  );

  // Free-running frame counter, 0..FS_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          tick <= '0;
    else if (tick == TW'(FS_DIV - 1))    tick <= '0;
    else                                 tick <= tick + TW'(1);
  end

  // Frame sequencer; SPI strobes, data_out and sample_trig are registered on
  // the transition into each state so they line up with the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      conv_cnt    <= '0;
      adc_cnv     <= 1'b0;
      adc_cs_n    <= 1'b1;
      data_out    <= '0;
      sample_trig <= 1'b0;
    end else begin
      sample_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (tick == '0 && enable) begin
            state    <= CONV;
            adc_cnv  <= 1'b1;
            conv_cnt <= '0;
          end
        end
        CONV: begin
          if (rx_start) begin
            state    <= READ;
            adc_cnv  <= 1'b0;
            adc_cs_n <= 1'b0;
          end else begin
            conv_cnt <= conv_cnt + CW'(1);
          end
        end
        READ: begin
          if (rx_busy && rx_last) begin
            state       <= DONE;
            adc_cs_n    <= 1'b1;
            data_out    <= sample_word;
            sample_trig <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake: sample_trig offers a new word (held until the next DONE);
  // filter_done acknowledges the outstanding word. A trig that lands while a
  // word is still unacknowledged is an overrun, unless filter_done arrives in
  // that same cycle (it retires the old word; the new one becomes pending).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (sample_trig)      pending <= 1'b1;
      else if (filter_done) pending <= 1'b0;
      if (sample_trig && pending && !filter_done) overrun <= 1'b1;
      else if (ovr_clr)                           overrun <= 1'b0;
    end
  end

endmodule
